// File: rtl/std_mem_d1_arb.sv
// rtl/std_mem_d1_arb.sv - two-client round-robin arbiter in front of one std_mem_d1
// Grants are latched in IDLE; the owner's request is held internally until its done pulse.

module std_mem_d1_arb #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c0_go,
   input  logic [IDX_SIZE-1:0] c0_addr,
   input  logic [WIDTH-1:0]    c0_write_data,
   input  logic                c0_write_en,
   output logic [WIDTH-1:0]    c0_read_data,
   output logic                c0_done,
   input  logic                c1_go,
   input  logic [IDX_SIZE-1:0] c1_addr,
   input  logic [WIDTH-1:0]    c1_write_data,
   input  logic                c1_write_en,
   output logic [WIDTH-1:0]    c1_read_data,
   output logic                c1_done,
   output logic [IDX_SIZE-1:0] mem_addr0,
   output logic [WIDTH-1:0]    mem_write_data,
   output logic                mem_write_en,
   input  logic [WIDTH-1:0]    mem_read_data,
   input  logic                mem_done
);

   // SIZE is informational; only a zero-depth instance would change the address width
   localparam int ADDR_W = (SIZE > 0) ? IDX_SIZE : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_owner;
   logic                r_prio;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [WIDTH-1:0]    r_wdata;
   logic [WIDTH-1:0]    r_c0_rdata;
   logic [WIDTH-1:0]    r_c1_rdata;

   logic                w_any_go;
   logic                w_grant;

   assign w_any_go = c0_go | c1_go;
   assign w_grant  = (c0_go && c1_go) ? r_prio : c1_go;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_go) w_next = S_ACCESS;
         S_ACCESS: w_next = r_we ? S_WAIT : S_DONE;
         S_WAIT:   if (mem_done) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr0      = '0;
      mem_write_data = '0;
      mem_write_en   = 1'b0;
      c0_done        = 1'b0;
      c1_done        = 1'b0;
      case (r_state)
         S_ACCESS: begin
            mem_addr0      = r_addr;
            mem_write_data = r_wdata;
            mem_write_en   = r_we;
         end
         S_WAIT: begin
            mem_addr0      = r_addr;
            mem_write_data = r_wdata;
         end
         S_DONE: begin
            c0_done = ~r_owner;
            c1_done = r_owner;
         end
         default: ;
      endcase
   end

   // The winner's request is captured at grant so a client dropping go mid-access is harmless
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner <= 1'b0;
         r_prio  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         if (r_state == S_IDLE && w_any_go) begin
            r_owner <= w_grant;
            r_we    <= w_grant ? c1_write_en   : c0_write_en;
            r_addr  <= w_grant ? c1_addr       : c0_addr;
            r_wdata <= w_grant ? c1_write_data : c0_write_data;
         end
         if (r_state == S_DONE) begin
            r_prio <= ~r_owner;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_c0_rdata <= '0;
         r_c1_rdata <= '0;
      end else if (r_state == S_ACCESS && !r_we) begin
         if (r_owner) begin
            r_c1_rdata <= mem_read_data;
         end else begin
            r_c0_rdata <= mem_read_data;
         end
      end
   end

   assign c0_read_data = r_c0_rdata;
   assign c1_read_data = r_c1_rdata;

endmodule

// File: tb/tb_std_mem_d1_arb.sv
// tb/tb_std_mem_d1_arb.sv - self-checking bench for std_mem_d1_arb
// Table-driven single transactions, hand-written corner sequences, then randomized traffic.

module tb_std_mem_d1_arb;

   localparam int W  = 32;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [1:0]           go;
   logic [1:0]           we;
   logic [1:0][IW-1:0]   addr;
   logic [1:0][W-1:0]    wd;
   logic [1:0][W-1:0]    rd;
   logic [1:0]           done;
   logic [IW-1:0]        mem_addr0;
   logic [W-1:0]         mem_wdata;
   logic [W-1:0]         mem_rdata;
   logic                 mem_we;
   logic                 mem_done = 1'b0;

   logic [W-1:0]         mem [16];
   logic                 mem_clear;
   int                   ack_delay;
   int                   ack_cnt = 0;

   int checks = 0;
   int errors = 0;

   std_mem_d1_arb #(.WIDTH(W), .SIZE(16), .IDX_SIZE(IW)) dut (
      .clk            (clk),
      .reset          (reset_n),
      .c0_go          (go[0]),
      .c0_addr        (addr[0]),
      .c0_write_data  (wd[0]),
      .c0_write_en    (we[0]),
      .c0_read_data   (rd[0]),
      .c0_done        (done[0]),
      .c1_go          (go[1]),
      .c1_addr        (addr[1]),
      .c1_write_data  (wd[1]),
      .c1_write_en    (we[1]),
      .c1_read_data   (rd[1]),
      .c1_done        (done[1]),
      .mem_addr0      (mem_addr0),
      .mem_write_data (mem_wdata),
      .mem_write_en   (mem_we),
      .mem_read_data  (mem_rdata),
      .mem_done       (mem_done)
   );

   always #5 clk = ~clk;

   // std_mem_d1 model: combinational read, registered write, done after ack_delay extra cycles
   assign mem_rdata = mem[mem_addr0];

   always @(posedge clk) begin
      mem_done <= 1'b0;
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         ack_cnt <= 0;
      end else if (mem_we) begin
         mem[mem_addr0] <= mem_wdata;
         if (ack_delay == 0) mem_done <= 1'b1;
         else ack_cnt <= ack_delay;
      end else if (ack_cnt > 0) begin
         ack_cnt <= ack_cnt - 1;
         if (ack_cnt == 1) mem_done <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts at a negedge with the arbiter idle; returns one cycle after done, arbiter idle again.
   task automatic run_txn(input logic cl, input logic w, input logic [IW-1:0] a,
                          input logic [W-1:0] d, output int lat, output int we_first,
                          output int we_cnt, output int other_done);
      go[cl] = 1'b1; we[cl] = w; addr[cl] = a; wd[cl] = d;
      lat = -1; we_first = -1; we_cnt = 0; other_done = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (mem_we) begin
            we_cnt++;
            if (we_first < 0) we_first = i;
         end
         if (done[!cl]) other_done++;
         if (done[cl]) begin
            lat = i;
            break;
         end
      end
      go[cl] = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      go = '0;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic           cl;
      logic           w;
      logic [IW-1:0]  a;
      logic [W-1:0]   d;
      int             lat;
      logic [W-1:0]   rd0;
      logic [W-1:0]   rd1;
   } vec_t;

   vec_t vt[9];

   // Reference model state for the random phase
   logic [W-1:0]  ref_mem [16];
   logic [W-1:0]  m_rd [2];
   int            m_last, m_own, m_dec, m_done_at, m_idle_at;
   bit            m_busy, m_we;
   logic [IW-1:0] m_a;
   logic [W-1:0]  m_d, m_val;
   bit            act [2];

   initial begin
      int lat, we_first, we_cnt, other_done;
      int dcyc [$];
      int dcl [$];
      int mdone_cyc, done_cyc;

      vt[0] = '{1'b0, 1'b1, 4'd3,  32'h0000_00A5, 3, 32'h0,          32'h0};
      vt[1] = '{1'b0, 1'b0, 4'd3,  32'h0,         2, 32'h0000_00A5,  32'h0};
      vt[2] = '{1'b1, 1'b0, 4'd3,  32'h0,         2, 32'h0000_00A5,  32'h0000_00A5};
      vt[3] = '{1'b1, 1'b1, 4'd7,  32'h0000_005A, 3, 32'h0000_00A5,  32'h0000_00A5};
      vt[4] = '{1'b0, 1'b0, 4'd7,  32'h0,         2, 32'h0000_005A,  32'h0000_00A5};
      vt[5] = '{1'b1, 1'b1, 4'd0,  32'hFFFF_FFFF, 3, 32'h0000_005A,  32'h0000_00A5};
      vt[6] = '{1'b1, 1'b0, 4'd0,  32'h0,         2, 32'h0000_005A,  32'hFFFF_FFFF};
      vt[7] = '{1'b0, 1'b1, 4'd3,  32'h0000_1234, 3, 32'h0000_005A,  32'hFFFF_FFFF};
      vt[8] = '{1'b1, 1'b0, 4'd3,  32'h0,         2, 32'h0000_005A,  32'h0000_1234};

      go = '0; we = '0; addr = '0; wd = '0;
      ack_delay = 0;
      mem_clear = 1'b1;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_c0_done", 32'(done[0]), 32'd0);
      chk("reset_c1_done", 32'(done[1]), 32'd0);
      chk("reset_c0_rd", rd[0], 32'd0);
      chk("reset_c1_rd", rd[1], 32'd0);
      chk("reset_mem_we", 32'(mem_we), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr0), 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      mem_clear = 1'b0;
      reset_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         run_txn(vt[v].cl, vt[v].w, vt[v].a, vt[v].d, lat, we_first, we_cnt, other_done);
         chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vt[v].lat));
         chk($sformatf("vec%0d_we_cycles", v), 32'(we_cnt), vt[v].w ? 32'd1 : 32'd0);
         if (vt[v].w) chk($sformatf("vec%0d_we_at", v), 32'(we_first), 32'd1);
         chk($sformatf("vec%0d_other_done", v), 32'(other_done), 32'd0);
         chk($sformatf("vec%0d_c0_rd", v), rd[0], vt[v].rd0);
         chk($sformatf("vec%0d_c1_rd", v), rd[1], vt[v].rd1);
      end

      // Both clients rise together after reset and hold go: grants 0,1,0,1
      pulse_reset();
      we = '0; addr[0] = 4'd3; addr[1] = 4'd7;
      go = 2'b11;
      for (int i = 1; i <= 40 && dcl.size() < 4; i++) begin
         @(negedge clk);
         if (done[0]) begin dcl.push_back(0); dcyc.push_back(i); end
         if (done[1]) begin dcl.push_back(1); dcyc.push_back(i); end
      end
      go = '0;
      @(negedge clk);
      chk("both_grant_count", 32'(dcl.size()), 32'd4);
      for (int i = 0; i < dcl.size() && i < 4; i++) begin
         chk($sformatf("both_grant%0d_client", i), 32'(dcl[i]), 32'(i % 2));
         chk($sformatf("both_grant%0d_cycle", i), 32'(dcyc[i]), 32'(2 + 3 * i));
      end
      chk("both_c0_rd", rd[0], 32'h0000_1234);
      chk("both_c1_rd", rd[1], 32'h0000_005A);

      // c1 write with memory ack held off 5 cycles
      ack_delay = 5;
      go[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd9; wd[1] = 32'h00C0_FFEE;
      mdone_cyc = -1; done_cyc = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 6) begin
            chk($sformatf("wait%0d_mem_we", i), 32'(mem_we), 32'd0);
            chk($sformatf("wait%0d_mem_addr", i), 32'(mem_addr0), 32'd9);
            chk($sformatf("wait%0d_c1_done", i), 32'(done[1]), 32'd0);
         end
         if (mem_done && mdone_cyc < 0) mdone_cyc = i;
         if (done[1]) begin
            done_cyc = i;
            break;
         end
      end
      go[1] = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      chk("wait_mem_done_cycle", 32'(mdone_cyc), 32'd7);
      chk("wait_done_cycle", 32'(done_cyc), 32'd8);

      // Reset while a write is in ACCESS
      go[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd5; wd[0] = 32'h77;
      @(negedge clk);
      chk("rstmid_we_before", 32'(mem_we), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rstmid_we_after", 32'(mem_we), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      chk("rstmid_c0_rd", rd[0], 32'd0);
      go = '0;
      @(negedge clk);
      reset_n = 1'b1;
      other_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done != 2'b00 || mem_we) other_done++;
      end
      chk("rstmid_no_activity", 32'(other_done), 32'd0);

      // Client drops go right after being granted; access still completes
      go[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd9;
      @(negedge clk);
      go[0] = 1'b0;
      lat = -1;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (done[0]) begin
            lat = i;
            break;
         end
      end
      chk("drop_go_latency", 32'(lat), 32'd2);
      chk("drop_go_rd", rd[0], 32'h00C0_FFEE);
      @(negedge clk);

      // Randomized traffic against a transaction-level model
      pulse_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      m_rd[0] = '0; m_rd[1] = '0;
      m_last = 1; m_busy = 0; m_idle_at = 0; m_dec = 0; m_done_at = 0; m_own = 0;
      m_we = 0; m_a = '0; m_d = '0; m_val = '0;
      act[0] = 0; act[1] = 0;
      for (int k = 0; k < 3000; k++) begin
         logic in_acc;
         @(negedge clk);
         if (m_busy && k == m_done_at && !m_we) m_rd[m_own] = m_val;
         in_acc = m_busy && k > m_dec && k < m_done_at;
         chk("rnd_c0_done", 32'(done[0]), 32'(m_busy && k == m_done_at && m_own == 0));
         chk("rnd_c1_done", 32'(done[1]), 32'(m_busy && k == m_done_at && m_own == 1));
         chk("rnd_mem_we", 32'(mem_we), 32'(m_busy && m_we && k == m_dec + 1));
         chk("rnd_mem_addr", 32'(mem_addr0), in_acc ? 32'(m_a) : 32'd0);
         chk("rnd_mem_wdata", mem_wdata, in_acc ? m_d : 32'd0);
         chk("rnd_c0_rd", rd[0], m_rd[0]);
         chk("rnd_c1_rd", rd[1], m_rd[1]);
         if (m_busy && k == m_done_at) begin
            m_busy = 0;
            m_last = m_own;
            m_idle_at = k + 1;
         end
         for (int c = 0; c < 2; c++) begin
            bit start;
            start = 0;
            if (act[c] && done[c]) begin
               act[c] = 0;
               go[c] = 1'b0;
               start = ($urandom_range(1) == 1);
            end else if (!act[c]) begin
               start = ($urandom_range(3) == 0);
            end
            if (start) begin
               act[c] = 1;
               go[c] = 1'b1;
               we[c] = 1'($urandom_range(1));
               addr[c] = 4'($urandom_range(15));
               wd[c] = $urandom;
            end
         end
         if (!m_busy && k >= m_idle_at && go != 2'b00) begin
            m_own = (go == 2'b11) ? (1 - m_last) : (go[1] ? 1 : 0);
            m_busy = 1;
            m_dec = k;
            m_we = we[m_own];
            m_a = addr[m_own];
            m_d = wd[m_own];
            if (m_we) begin
               ref_mem[m_a] = m_d;
               m_done_at = k + 3;
            end else begin
               m_val = ref_mem[m_a];
               m_done_at = k + 2;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
